pc_next_unit: RTL and testbench

//   Program-counter and fetch-request stage sitting directly downstream of the branch AND gate
//   (BranchTaken = Branch && Zero). Holds the PC, issues fetch requests to instruction memory

---
 rtl/pc_pkg.sv | 34 +++
 rtl/sat_counter.sv | 49 ++++
 rtl/pc_next_unit.sv | 178 +++++++++++++++++
 tb/tb_pc_next_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// ============================================================================
// pc_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the program-counter / fetch-request stage.
//
//   pc_state_e  : sequencing states of pc_next_unit
//                 BOOT     - first cycle after reset, no request issued yet
//                 FETCH    - normal operation, request valid, PC advances on accept
//                 REDIRECT - one-cycle bubble after a taken branch or jump
//   PC_INC      : byte increment between sequential instruction words
//   ALIGN_MASK  : clears the two low address bits of a redirect target
//                 (sliced down to the PC width by the user)
//
// No configuration macros are used in this file.
// ============================================================================
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2
    } pc_state_e;

    localparam int PC_INC = 4;

    // Wide enough for any sensible PC width; only the low WIDTH bits are used.
    localparam logic [63:0] ALIGN_MASK = ~64'd3;

    // Force a target onto a word boundary.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage : pc_pkg

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
// ----------------------------------------------------------------------------
// Event counter that increments by one on each cycle 'inc' is high and sticks
// at its all-ones value instead of wrapping. Cleared by the asynchronous
// active-low reset.
//
// Parameters
//   CNT_W   counter width in bits
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset, clears the count
//   inc     in   1      count one event this cycle
//   count   out  CNT_W  current (registered) count
//
// Only instantiated by pc_next_unit when BRANCH_STATS_EN is defined.
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Once every bit is set the counter has saturated and ignores further events.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pc_next_unit.sv
// ============================================================================
// pc_next_unit
// ----------------------------------------------------------------------------
// Program-counter and fetch-request stage. Holds the PC, presents it to
// instruction memory with a valid/ready handshake and steps it by 4 each time
// the request is accepted. A taken branch or a jump redirects the PC to the
// (word-aligned) target, drops the request for one cycle and pulses Redirect
// so the IF/ID register can be flushed.
//
// Parameters
//   WIDTH     PC / target width in bits
//   RESET_PC  PC loaded on reset (word aligned)
//   CNT_W     width of the statistics counters
//
// Ports
//   Clk           in   1      rising-edge clock
//   Rst_n         in   1      asynchronous active-low reset
//   BranchTaken   in   1      branch resolved taken this cycle
//   BranchTarget  in   WIDTH  branch destination
//   Jump          in   1      unconditional jump resolved this cycle
//   JumpTarget    in   WIDTH  jump destination
//   Stall         in   1      hazard stall: hold PC, keep request pending
//   FetchReady    in   1      instruction memory accepts the request
//   FetchValid    out  1      fetch request valid
//   PC            out  WIDTH  fetch address (registered)
//   PCPlus4       out  WIDTH  PC + 4, combinational, wraps mod 2^WIDTH
//   Redirect      out  1      one-cycle flush pulse to IF/ID
//   TakenCount    out  CNT_W  taken-branch redirects (saturating)
//   JumpCount     out  CNT_W  jump redirects (saturating)
//
// Configuration macro
//   BRANCH_STATS_EN  when defined, TakenCount/JumpCount count accepted
//                    redirects of each kind (a jump wins when both occur).
//                    When undefined there is no counter logic and both
//                    count ports are driven to zero.
// ============================================================================
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Stall,
    input  logic             FetchReady,
    output logic             FetchValid,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             Redirect,
    output logic [CNT_W-1:0] TakenCount,
    output logic [CNT_W-1:0] JumpCount
);

    pc_state_e        state_q;
    pc_state_e        state_d;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             valid_q;
    logic             valid_d;
    logic             redirect_q;
    logic             redirect_d;

    logic [WIDTH-1:0] branch_target_aligned;
    logic [WIDTH-1:0] jump_target_aligned;
    logic             accept;

    assign branch_target_aligned = BranchTarget & ALIGN_MASK[WIDTH-1:0];
    assign jump_target_aligned   = JumpTarget & ALIGN_MASK[WIDTH-1:0];

    // A request can only be consumed from FETCH; in REDIRECT the request is
    // already low so the handshake cannot complete there anyway.
    assign accept = (state_q == FETCH) && valid_q && FetchReady && !Stall;

    // Next-state and next-output selection. Priority once out of BOOT is
    // Jump > BranchTaken > Stall > accept > hold. A redirect is allowed to
    // abandon a request that memory has not yet accepted, and a redirect that
    // arrives during the bubble simply restarts the bubble at the new target.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        redirect_d = redirect_q;

        unique case (state_q)
            BOOT: begin
                // Resolved branches/jumps are ignored until the first request is up.
                state_d    = FETCH;
                valid_d    = 1'b1;
                redirect_d = 1'b0;
            end

            FETCH, REDIRECT: begin
                if (Jump) begin
                    state_d    = REDIRECT;
                    pc_d       = jump_target_aligned;
                    valid_d    = 1'b0;
                    redirect_d = 1'b1;
                end else if (BranchTaken) begin
                    state_d    = REDIRECT;
                    pc_d       = branch_target_aligned;
                    valid_d    = 1'b0;
                    redirect_d = 1'b1;
                end else begin
                    state_d    = FETCH;
                    valid_d    = 1'b1;
                    redirect_d = 1'b0;
                    if (accept) begin
                        pc_d = pc_q + WIDTH'(PC_INC);
                    end
                end
            end

            default: begin
                state_d    = BOOT;
                valid_d    = 1'b0;
                redirect_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset takes effect immediately in any state.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            redirect_q <= redirect_d;
        end
    end

    assign PC         = pc_q;
    assign PCPlus4    = pc_q + WIDTH'(PC_INC);
    assign FetchValid = valid_q;
    assign Redirect   = redirect_q;

`ifdef BRANCH_STATS_EN
    logic jump_redirect;
    logic taken_redirect;

    // A redirect only counts once the unit has left BOOT; a jump takes the
    // credit when it coincides with a taken branch.
    assign jump_redirect  = (state_q != BOOT) && Jump;
    assign taken_redirect = (state_q != BOOT) && !Jump && BranchTaken;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_taken_counter (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (taken_redirect),
        .count (TakenCount)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_jump_counter (
        .clk   (Clk),
        .rst_n (Rst_n),
        .inc   (jump_redirect),
        .count (JumpCount)
    );
`else
    assign TakenCount = '0;
    assign JumpCount  = '0;
`endif

endmodule : pc_next_unit

// File: tb/tb_pc_next_unit.sv
// ============================================================================
// tb_pc_next_unit
// ----------------------------------------------------------------------------
// Self-checking bench for pc_next_unit. Two instances share all inputs:
//   dut_a : default parameters (RESET_PC = 0, CNT_W = 16)
//   dut_b : RESET_PC = 32'hFFFF_FFFC, CNT_W = 2 (PC wrap and counter saturation)
// A behavioural model tracks each instance in terms of the observable rules
// (booted or not, request valid, redirect pulse, PC, event counts).
// Honours BRANCH_STATS_EN: counters are expected to be zero when undefined.
// ============================================================================
`timescale 1ns/1ps

module tb_pc_next_unit;

`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFFC;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        stall;
    logic        fetch_ready;

    logic        valid_a, redir_a, valid_b, redir_b;
    logic [31:0] pc_a, pc4_a, pc_b, pc4_b;
    logic [15:0] tcnt_a, jcnt_a;
    logic [1:0]  tcnt_b, jcnt_b;

    int checks;
    int fails;

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic        redirect;
        logic        booted;
        int          tcnt;
        int          jcnt;
    } model_t;

    model_t m_a;
    model_t m_b;

    pc_next_unit #(.WIDTH(32), .RESET_PC(32'h0), .CNT_W(16)) dut_a (
        .Clk(clk), .Rst_n(rst_n),
        .BranchTaken(branch_taken), .BranchTarget(branch_target),
        .Jump(jump), .JumpTarget(jump_target),
        .Stall(stall), .FetchReady(fetch_ready),
        .FetchValid(valid_a), .PC(pc_a), .PCPlus4(pc4_a), .Redirect(redir_a),
        .TakenCount(tcnt_a), .JumpCount(jcnt_a)
    );

    pc_next_unit #(.WIDTH(32), .RESET_PC(RESET_PC_B), .CNT_W(2)) dut_b (
        .Clk(clk), .Rst_n(rst_n),
        .BranchTaken(branch_taken), .BranchTarget(branch_target),
        .Jump(jump), .JumpTarget(jump_target),
        .Stall(stall), .FetchReady(fetch_ready),
        .FetchValid(valid_b), .PC(pc_b), .PCPlus4(pc4_b), .Redirect(redir_b),
        .TakenCount(tcnt_b), .JumpCount(jcnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state just after reset.
    function automatic model_t model_reset(input logic [31:0] rpc);
        model_t m;
        m.pc = rpc; m.valid = 1'b0; m.redirect = 1'b0; m.booted = 1'b0;
        m.tcnt = 0; m.jcnt = 0;
        return m;
    endfunction

    // One clock of behaviour from the rules: the first cycle after reset only
    // raises the request; afterwards jumps beat branches, a redirect bubbles
    // the request, and an outstanding request advances the PC when memory
    // takes it without a stall.
    function automatic model_t model_next(input model_t m, input logic j, input logic [31:0] jt,
                                          input logic b, input logic [31:0] bt,
                                          input logic st, input logic rdy, input int cmax);
        model_t n = m;
        if (!m.booted) begin
            n.booted = 1'b1; n.valid = 1'b1; n.redirect = 1'b0;
        end else if (j || b) begin
            n.pc       = (j ? jt : bt) / 4 * 4;
            n.valid    = 1'b0;
            n.redirect = 1'b1;
            if (j) n.jcnt = (m.jcnt < cmax) ? m.jcnt + 1 : cmax;
            else   n.tcnt = (m.tcnt < cmax) ? m.tcnt + 1 : cmax;
        end else begin
            if (m.valid && rdy && !st) n.pc = m.pc + 32'd4;
            n.valid = 1'b1; n.redirect = 1'b0;
        end
        return n;
    endfunction

    // Advance model and DUTs by one clock; outputs are observed at the falling edge.
    task automatic tick();
        m_a = model_next(m_a, jump, jump_target, branch_taken, branch_target, stall, fetch_ready, 65535);
        m_b = model_next(m_b, jump, jump_target, branch_taken, branch_target, stall, fetch_ready, 3);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_inputs(input logic j, input logic [31:0] jt, input logic b,
                              input logic [31:0] bt, input logic st, input logic rdy);
        jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        stall = st; fetch_ready = rdy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        m_a = model_reset(32'h0);
        m_b = model_reset(RESET_PC_B);
        checks++; if (pc_a !== 32'h0) begin fails++; $display("FAIL reset_pc_a: got %h expected %h", pc_a, 32'h0); end
        checks++; if (pc_b !== RESET_PC_B) begin fails++; $display("FAIL reset_pc_b: got %h expected %h", pc_b, RESET_PC_B); end
        checks++; if ({valid_a, redir_a, valid_b, redir_b} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {valid_a, redir_a, valid_b, redir_b}); end
        checks++; if ({tcnt_a, jcnt_a, tcnt_b, jcnt_b} !== 36'h0) begin fails++; $display("FAIL reset_counts: got %h expected 0", {tcnt_a, jcnt_a, tcnt_b, jcnt_b}); end
        rst_n = 1'b1;
        // A jump offered during BOOT must be ignored.
        set_inputs(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b1);
        checks++; if (valid_a !== 1'b0) begin fails++; $display("FAIL boot_valid_low: got %b expected 0", valid_a); end
        tick();
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h0 || redir_a !== 1'b0) begin fails++; $display("FAIL boot_exit: got valid=%b pc=%h redirect=%b expected valid=1 pc=0 redirect=0", valid_a, pc_a, redir_a); end
        checks++; if ({tcnt_a, jcnt_a} !== 32'h0) begin fails++; $display("FAIL boot_no_count: got %h expected 0", {tcnt_a, jcnt_a}); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if (pc_a !== 32'h0 || pc4_a !== 32'h4) begin fails++; $display("FAIL seq_start: got pc=%h pc4=%h expected 0/4", pc_a, pc4_a); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            exp_pc = 32'd4 * i;
            checks++; if (pc_a !== exp_pc) begin fails++; $display("FAIL seq_pc: got %h expected %h", pc_a, exp_pc); end
            checks++; if (pc4_a !== exp_pc + 32'd4) begin fails++; $display("FAIL seq_pc4: got %h expected %h", pc4_a, exp_pc + 32'd4); end
            if (i == 1) begin
                checks++; if (pc_b !== 32'h0 || pc4_b !== 32'h4) begin fails++; $display("FAIL wrap_pc_b: got pc=%h pc4=%h expected 0/4", pc_b, pc4_b); end
            end
        end
    endtask

    task automatic test_ready_hold();
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc_a !== 32'h8 || valid_a !== 1'b1) begin fails++; $display("FAIL hold_not_ready: got pc=%h valid=%b expected 8/1", pc_a, valid_a); end
        end
        fetch_ready = 1'b1;
        tick();
        checks++; if (pc_a !== 32'hC) begin fails++; $display("FAIL hold_release: got %h expected %h", pc_a, 32'hC); end
        tick();
        checks++; if (pc_a !== 32'h10) begin fails++; $display("FAIL hold_step: got %h expected %h", pc_a, 32'h10); end
    endtask

    task automatic test_branch_over_stall();
        set_inputs(1'b0, 32'h0, 1'b1, 32'h43, 1'b1, 1'b1);
        tick();
        checks++; if (pc_a !== 32'h40 || redir_a !== 1'b1 || valid_a !== 1'b0) begin fails++; $display("FAIL branch_redirect: got pc=%h redirect=%b valid=%b expected 40/1/0", pc_a, redir_a, valid_a); end
        checks++; if (tcnt_a !== (STATS ? 16'd1 : 16'd0)) begin fails++; $display("FAIL branch_count: got %0d expected %0d", tcnt_a, STATS ? 1 : 0); end
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checks++; if (pc_a !== 32'h40 || redir_a !== 1'b0 || valid_a !== 1'b1) begin fails++; $display("FAIL branch_bubble_end: got pc=%h redirect=%b valid=%b expected 40/0/1", pc_a, redir_a, valid_a); end
    endtask

    task automatic test_jump_priority();
        set_inputs(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 1'b1);
        tick();
        checks++; if (pc_a !== 32'h100 || redir_a !== 1'b1) begin fails++; $display("FAIL jump_priority: got pc=%h redirect=%b expected 100/1", pc_a, redir_a); end
        checks++; if (jcnt_a !== (STATS ? 16'd1 : 16'd0) || tcnt_a !== (STATS ? 16'd1 : 16'd0)) begin fails++; $display("FAIL jump_counts: got jump=%0d taken=%0d expected %0d/%0d", jcnt_a, tcnt_a, STATS ? 1 : 0, STATS ? 1 : 0); end
        // A second redirect inside the bubble restarts it at the new target.
        set_inputs(1'b0, 32'h0, 1'b1, 32'h206, 1'b0, 1'b1);
        tick();
        checks++; if (pc_a !== 32'h204 || redir_a !== 1'b1 || valid_a !== 1'b0) begin fails++; $display("FAIL redirect_in_bubble: got pc=%h redirect=%b valid=%b expected 204/1/0", pc_a, redir_a, valid_a); end
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        checks++; if (pc_a !== 32'h204 || valid_a !== 1'b1 || redir_a !== 1'b0) begin fails++; $display("FAIL redirect_resume: got pc=%h valid=%b redirect=%b expected 204/1/0", pc_a, valid_a, redir_a); end
        // Pending unaccepted request abandoned by a branch.
        set_inputs(1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 1'b0);
        tick();
        checks++; if (pc_a !== 32'h3000) begin fails++; $display("FAIL abandon_pending: got %h expected %h", pc_a, 32'h3000); end
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_saturation();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (pc_a !== 32'h0 || pc_b !== RESET_PC_B || valid_a !== 1'b0 || tcnt_a !== 16'd0) begin fails++; $display("FAIL async_reset: got pc_a=%h pc_b=%h valid=%b taken=%0d expected 0/%h/0/0", pc_a, pc_b, valid_a, tcnt_a, RESET_PC_B); end
        m_a = model_reset(32'h0);
        m_b = model_reset(RESET_PC_B);
        @(negedge clk);
        rst_n = 1'b1;
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i * 16), 1'b0, 1'b1);
            tick();
        end
        checks++; if (tcnt_b !== (STATS ? 2'd3 : 2'd0)) begin fails++; $display("FAIL sat_taken_b: got %0d expected %0d", tcnt_b, STATS ? 3 : 0); end
        checks++; if (tcnt_a !== (STATS ? 16'd5 : 16'd0)) begin fails++; $display("FAIL count_taken_a: got %0d expected %0d", tcnt_a, STATS ? 5 : 0); end
        checks++; if (pc_a !== 32'h1040 || redir_a !== 1'b1) begin fails++; $display("FAIL back_to_back_redirect: got pc=%h redirect=%b expected 1040/1", pc_a, redir_a); end
        set_inputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_random();
        logic [31:0] e4;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                checks++; if (pc_a !== 32'h0 || pc_b !== RESET_PC_B || {valid_a, redir_a, valid_b, redir_b} !== 4'b0) begin fails++; $display("FAIL rand_async_reset: got pc_a=%h pc_b=%h flags=%b", pc_a, pc_b, {valid_a, redir_a, valid_b, redir_b}); end
                m_a = model_reset(32'h0);
                m_b = model_reset(RESET_PC_B);
                @(negedge clk);
                rst_n = 1'b1;
            end
            set_inputs($urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 6) == 0, $urandom,
                       $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
            tick();
            e4 = m_a.pc + 32'd4;
            checks++; if (pc_a !== m_a.pc || pc4_a !== e4) begin fails++; $display("FAIL rand_pc_a: got pc=%h pc4=%h expected %h/%h", pc_a, pc4_a, m_a.pc, e4); end
            checks++; if (valid_a !== m_a.valid || redir_a !== m_a.redirect) begin fails++; $display("FAIL rand_flags_a: got valid=%b redirect=%b expected %b/%b", valid_a, redir_a, m_a.valid, m_a.redirect); end
            checks++; if (tcnt_a !== (STATS ? 16'(m_a.tcnt) : 16'd0) || jcnt_a !== (STATS ? 16'(m_a.jcnt) : 16'd0)) begin fails++; $display("FAIL rand_counts_a: got %0d/%0d expected %0d/%0d", tcnt_a, jcnt_a, STATS ? m_a.tcnt : 0, STATS ? m_a.jcnt : 0); end
            e4 = m_b.pc + 32'd4;
            checks++; if (pc_b !== m_b.pc || pc4_b !== e4) begin fails++; $display("FAIL rand_pc_b: got pc=%h pc4=%h expected %h/%h", pc_b, pc4_b, m_b.pc, e4); end
            checks++; if (valid_b !== m_b.valid || redir_b !== m_b.redirect) begin fails++; $display("FAIL rand_flags_b: got valid=%b redirect=%b expected %b/%b", valid_b, redir_b, m_b.valid, m_b.redirect); end
            checks++; if (tcnt_b !== (STATS ? 2'(m_b.tcnt) : 2'd0) || jcnt_b !== (STATS ? 2'(m_b.jcnt) : 2'd0)) begin fails++; $display("FAIL rand_counts_b: got %0d/%0d expected %0d/%0d", tcnt_b, jcnt_b, STATS ? m_b.tcnt : 0, STATS ? m_b.jcnt : 0); end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_sequential();
        test_ready_hold();
        test_branch_over_stall();
        test_jump_priority();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_pc_next_unit
